// File: rtl/bam_integrated.sv
// Registered 32x32 signed multiplier: operand registers A and B feed a radix-2 Booth array,
// and a 64-bit output register presents the product. Each register has its own enables and error flag.
module bam_integrated (
  input  logic        clk,
  input  logic        resetA,
  input  logic        resetB,
  input  logic        resetOut,
  input  logic [31:0] Multiplicand,
  input  logic [31:0] Multiplier,
  input  logic        writeEnableA,
  input  logic        writeEnableB,
  input  logic        writeEnableOut,
  input  logic        readEnableA,
  input  logic        readEnableB,
  input  logic        readEnableOut,
  output logic        accessErrorA,
  output logic        accessErrorB,
  output logic        accessErrorOut,
  output logic [63:0] Product
);

  logic [31:0] a_stored, a_dout;
  logic [31:0] b_stored, b_dout;
  logic [63:0] out_stored, out_dout;
  logic        a_err, b_err, out_err;
  logic [63:0] booth;

  // Simultaneous write and read is a conflict: contents hold, flag raised for that edge only.
  always_ff @(posedge clk or posedge resetA) begin
    if (resetA) begin
      a_stored <= '0;
      a_dout   <= '0;
      a_err    <= 1'b0;
    end else begin
      a_err <= writeEnableA & readEnableA;
      if (writeEnableA && !readEnableA) a_stored <= Multiplicand;
      if (readEnableA && !writeEnableA) a_dout <= a_stored;
    end
  end

  always_ff @(posedge clk or posedge resetB) begin
    if (resetB) begin
      b_stored <= '0;
      b_dout   <= '0;
      b_err    <= 1'b0;
    end else begin
      b_err <= writeEnableB & readEnableB;
      if (writeEnableB && !readEnableB) b_stored <= Multiplier;
      if (readEnableB && !writeEnableB) b_dout <= b_stored;
    end
  end

  always_ff @(posedge clk or posedge resetOut) begin
    if (resetOut) begin
      out_stored <= '0;
      out_dout   <= '0;
      out_err    <= 1'b0;
    end else begin
      out_err <= writeEnableOut & readEnableOut;
      if (writeEnableOut && !readEnableOut) out_stored <= booth;
      if (readEnableOut && !writeEnableOut) out_dout <= out_stored;
    end
  end

  // Radix-2 Booth: the top pair treats b[31] as the sign, so -2^31 operands come out exact.
  logic [63:0] a_ext;
  logic [32:0] b_ext;
  always_comb begin
    a_ext = {{32{a_dout[31]}}, a_dout};
    b_ext = {b_dout, 1'b0};
    booth = '0;
    for (int i = 0; i < 32; i++) begin
      case (b_ext[i+1 -: 2])
        2'b01:   booth = booth + (a_ext << i);
        2'b10:   booth = booth - (a_ext << i);
        default: booth = booth;
      endcase
    end
  end

  assign Product        = out_dout;
  assign accessErrorA   = a_err;
  assign accessErrorB   = b_err;
  assign accessErrorOut = out_err;

endmodule

// File: tb/tb_bam_integrated.sv
// Bench for bam_integrated: table-driven 4-edge sequences with a product scoreboard,
// plus hand-written conflict and mid-sequence reset cases.
module tb_bam_integrated;

  logic        clk = 1'b0;
  logic        resetA, resetB, resetOut;
  logic [31:0] Multiplicand, Multiplier;
  logic        writeEnableA, writeEnableB, writeEnableOut;
  logic        readEnableA, readEnableB, readEnableOut;
  logic        accessErrorA, accessErrorB, accessErrorOut;
  logic [63:0] Product;

  bam_integrated dut (
    .clk            (clk),
    .resetA         (resetA),
    .resetB         (resetB),
    .resetOut       (resetOut),
    .Multiplicand   (Multiplicand),
    .Multiplier     (Multiplier),
    .writeEnableA   (writeEnableA),
    .writeEnableB   (writeEnableB),
    .writeEnableOut (writeEnableOut),
    .readEnableA    (readEnableA),
    .readEnableB    (readEnableB),
    .readEnableOut  (readEnableOut),
    .accessErrorA   (accessErrorA),
    .accessErrorB   (accessErrorB),
    .accessErrorOut (accessErrorOut),
    .Product        (Product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]        a;
    logic [31:0]        b;
    logic signed [63:0] p;
  } vec_t;

  vec_t    vecs[9];
  longint  exp_q[$];
  int      checks = 0;
  int      errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, $signed(act), act,
               $signed(req), req);
    end
  endtask

  // Called at a falling edge: hold the enables across one rising edge, then clear them.
  task automatic step(input logic wa, input logic wb, input logic ra, input logic rb,
                      input logic wo, input logic ro);
    writeEnableA = wa; writeEnableB = wb; writeEnableOut = wo;
    readEnableA  = ra; readEnableB  = rb; readEnableOut  = ro;
    @(negedge clk);
    writeEnableA = 0; writeEnableB = 0; writeEnableOut = 0;
    readEnableA  = 0; readEnableB  = 0; readEnableOut  = 0;
  endtask

  task automatic run_seq(input string name, input logic [31:0] a, input logic [31:0] b,
                         input longint p);
    longint req;
    Multiplicand = a;
    Multiplier   = b;
    exp_q.push_back(p);
    step(1, 1, 0, 0, 0, 0);
    Multiplicand = $urandom;  // no write enable, must be ignored
    Multiplier   = $urandom;
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 64'd1, 64'd0);
    end else begin
      req = exp_q.pop_front();
      check(name, Product, req);
      check({name, "_err"}, {61'd0, accessErrorA, accessErrorB, accessErrorOut}, 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required $finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    vecs[0] = '{32'h0CA01D87, 32'd12345,   64'sd2614916801295};
    vecs[1] = '{-32'sd2111,   -32'sd552233, 64'sd1165763863};
    vecs[2] = '{32'd502,      -32'sd4,      -64'sd2008};
    vecs[3] = '{-32'sd2111,   32'd125,      -64'sd263875};
    vecs[4] = '{32'h6CA02D87, 32'd0,        64'sd0};
    vecs[5] = '{32'd123456789, 32'd1,       64'sd123456789};
    vecs[6] = '{32'h7FFFFFFF, 32'h80000000, -64'sd4611686016279904256};
    vecs[7] = '{32'h80000000, 32'h80000000, 64'sd4611686018427387904};
    vecs[8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'sd1};

    resetA = 1; resetB = 1; resetOut = 1;
    Multiplicand = 32'h12345678; Multiplier = 32'h9ABCDEF0;
    writeEnableA = 0; writeEnableB = 0; writeEnableOut = 0;
    readEnableA  = 0; readEnableB  = 0; readEnableOut  = 0;
    #3;
    check("reset_product", Product, 64'd0);
    check("reset_errA", {63'd0, accessErrorA}, 64'd0);
    check("reset_errB", {63'd0, accessErrorB}, 64'd0);
    check("reset_errOut", {63'd0, accessErrorOut}, 64'd0);
    @(negedge clk);
    resetA = 0; resetB = 0; resetOut = 0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_seq($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_seq($sformatf("rand%0d", i), ra, rb, longint'($signed(ra)) * longint'($signed(rb)));
    end

    // Conflict on A: flag for one cycle, stored value must survive.
    run_seq("conf_setup", 32'd5, 32'd3, 64'sd15);
    Multiplicand = 32'd99;
    step(1, 0, 1, 0, 0, 0);
    check("conf_errA_set", {63'd0, accessErrorA}, 64'd1);
    step(0, 0, 0, 0, 0, 0);
    check("conf_errA_clear", {63'd0, accessErrorA}, 64'd0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    check("conf_stored_kept", Product, 64'd15);

    // Writing new operands without a read leaves Product alone; no-read Out write too.
    Multiplicand = 32'd1000; Multiplier = 32'd1000;
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    check("write_no_read", Product, 64'd15);

    // Write on Out with read on A in the same edge uses the pre-edge A.dout (5): 5*1000.
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    check("mixed_edge", Product, 64'd5000);

    // resetOut mid-sequence, with an Out conflict flag pending.
    Multiplicand = 32'd9; Multiplier = 32'd11;
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1);
    check("out_conf_set", {63'd0, accessErrorOut}, 64'd1);
    check("out_before_reset", Product, 64'd5000);
    #2 resetOut = 1;
    #1;
    check("rstout_product", Product, 64'd0);
    check("rstout_err", {63'd0, accessErrorOut}, 64'd0);
    #1 resetOut = 0;
    @(negedge clk);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    check("rstout_rerun", Product, 64'd99);

    // resetA clears A.dout, so a fresh Out capture yields 0.
    #2 resetA = 1;
    #2 resetA = 0;
    @(negedge clk);
    check("rsta_product_hold", Product, 64'd99);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    check("rsta_product_zero", Product, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
